// File: rtl/perceptron_uart_ctrl.sv
// Perceptron evaluator/trainer driven by a byte-oriented UART command protocol.
// Opcodes: 0x01 load inputs, 0x02 load weights, 0x03 evaluate, 0x04 train,
// 0x05 read weights; anything else is answered with 0xEE.
module perceptron_uart_ctrl #(
  parameter int unsigned N_INPUTS    = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RATE_SHIFT  = 0,
  parameter int unsigned TIMEOUT_CYC = 120000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  output logic       rx_clear,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       busy,
  output logic       result,
  output logic       overrun
);

  localparam int unsigned BPW         = DATA_W / 8;
  localparam int unsigned FRAME_BYTES = N_INPUTS * BPW;
  localparam int unsigned FRAME_W     = N_INPUTS * DATA_W;
  localparam int unsigned CNT_W       = $clog2(FRAME_BYTES + 1);
  localparam int unsigned IDX_W       = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int unsigned BYTE_W      = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned TMO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned ACC_W       = 2 * DATA_W + $clog2(N_INPUTS) + 1;
  localparam int unsigned PROD_W      = 2 * DATA_W;
  localparam int unsigned WW          = DATA_W + 2;

  localparam logic [7:0] OP_LOAD_IN = 8'h01;
  localparam logic [7:0] OP_LOAD_W  = 8'h02;
  localparam logic [7:0] OP_EVAL    = 8'h03;
  localparam logic [7:0] OP_TRAIN   = 8'h04;
  localparam logic [7:0] OP_READ_W  = 8'h05;
  localparam logic [7:0] ERR_BYTE   = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_PAYLOAD,
    S_MAC,
    S_UPDATE,
    S_TX_BYTE,
    S_TX_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [7:0]                op_q, op_d;
  logic [CNT_W-1:0]          rx_cnt_q, rx_cnt_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic [FRAME_W-1:0]        frame_q, frame_d;
  logic                      target_q, target_d;
  logic [IDX_W-1:0]          mac_idx_q, mac_idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]          tx_word_q, tx_word_d;
  logic [BYTE_W-1:0]         tx_byte_q, tx_byte_d;
  logic signed [DATA_W-1:0]  x_q [N_INPUTS];
  logic signed [DATA_W-1:0]  x_d [N_INPUTS];
  logic signed [DATA_W-1:0]  w_q [N_INPUTS];
  logic signed [DATA_W-1:0]  w_d [N_INPUTS];
  logic signed [DATA_W-1:0]  w_upd [N_INPUTS];
  logic                      result_d, overrun_d, tx_start_d, rx_clear_d, busy_d;
  logic [7:0]                tx_data_d;

  logic                      rx_byte;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_sum;
  logic                      last_tx;

  assign rx_byte = rx_valid & ~rx_error;

  // Single shared multiplier, one product per MAC cycle
  assign prod    = PROD_W'(x_q[mac_idx_q]) * PROD_W'(w_q[mac_idx_q]);
  assign acc_sum = acc_q + ACC_W'(prod);
  assign last_tx = (tx_word_q == IDX_W'(N_INPUTS - 1)) && (tx_byte_q == '0);

  // Candidate trained weights: w +/- (x >>> RATE_SHIFT), saturated to DATA_W
  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) begin
      logic signed [DATA_W-1:0] xs;
      logic signed [WW-1:0]     wide;
      xs   = x_q[i] >>> RATE_SHIFT;
      wide = target_q ? (WW'(w_q[i]) + WW'(xs)) : (WW'(w_q[i]) - WW'(xs));
      if ((wide[WW-1:DATA_W-1] == '0) || (wide[WW-1:DATA_W-1] == '1)) begin
        w_upd[i] = wide[DATA_W-1:0];
      end else if (wide[WW-1]) begin
        w_upd[i] = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        w_upd[i] = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rx_cnt_d   = rx_cnt_q;
    tmo_d      = tmo_q;
    frame_d    = frame_q;
    target_d   = target_q;
    mac_idx_d  = mac_idx_q;
    acc_d      = acc_q;
    tx_word_d  = tx_word_q;
    tx_byte_d  = tx_byte_q;
    x_d        = x_q;
    w_d        = w_q;
    result_d   = result;
    overrun_d  = overrun;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    rx_clear_d = rx_error;

    case (state_q)
      S_IDLE: begin
        rx_cnt_d  = '0;
        tmo_d     = '0;
        mac_idx_d = '0;
        acc_d     = '0;
        tx_word_d = '0;
        tx_byte_d = BYTE_W'(BPW - 1);
        if (rx_byte) begin
          op_d = rx_data;
          case (rx_data)
            OP_LOAD_IN, OP_LOAD_W, OP_TRAIN: state_d = S_RX_PAYLOAD;
            OP_EVAL:                         state_d = S_MAC;
            default:                         state_d = S_TX_BYTE;
          endcase
        end
      end

      S_RX_PAYLOAD: begin
        if (rx_error) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          tmo_d    = '0;
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
          frame_d  = (frame_q << 8) | FRAME_W'(rx_data);
          if (op_q == OP_TRAIN) begin
            target_d = rx_data[0];
            state_d  = S_MAC;
          end else if (rx_cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
            // Word 0 arrived first, so it sits in the most significant slot
            for (int i = 0; i < N_INPUTS; i++) begin
              if (op_q == OP_LOAD_IN) begin
                x_d[i] = frame_d[(N_INPUTS-1-i)*DATA_W +: DATA_W];
              end else begin
                w_d[i] = frame_d[(N_INPUTS-1-i)*DATA_W +: DATA_W];
              end
            end
            state_d = S_IDLE;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_MAC: begin
        acc_d     = acc_sum;
        mac_idx_d = mac_idx_q + IDX_W'(1);
        if (mac_idx_q == IDX_W'(N_INPUTS - 1)) begin
          result_d = ~acc_sum[ACC_W-1] && (acc_sum != '0);
          state_d  = (op_q == OP_TRAIN) ? S_UPDATE : S_TX_BYTE;
        end
      end

      S_UPDATE: begin
        if (target_q != result) begin
          w_d = w_upd;
        end
        state_d = S_TX_BYTE;
      end

      S_TX_BYTE: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          case (op_q)
            OP_EVAL, OP_TRAIN: tx_data_d = {7'b0, result};
            OP_READ_W:         tx_data_d = w_q[tx_word_q][{tx_byte_q, 3'b000} +: 8];
            default:           tx_data_d = ERR_BYTE;
          endcase
          state_d = S_TX_WAIT;
        end
      end

      S_TX_WAIT: begin
        // tx_busy may still be low this cycle; the next byte re-checks it
        if ((op_q == OP_READ_W) && !last_tx) begin
          if (tx_byte_q == '0) begin
            tx_byte_d = BYTE_W'(BPW - 1);
            tx_word_d = tx_word_q + IDX_W'(1);
          end else begin
            tx_byte_d = tx_byte_q - BYTE_W'(1);
          end
          state_d = S_TX_BYTE;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Bytes arriving while computing or replying are dropped
    if (rx_byte && (state_q inside {S_MAC, S_UPDATE, S_TX_BYTE, S_TX_WAIT})) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rx_cnt_q  <= '0;
      tmo_q     <= '0;
      frame_q   <= '0;
      target_q  <= 1'b0;
      mac_idx_q <= '0;
      acc_q     <= '0;
      tx_word_q <= '0;
      tx_byte_q <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
      result    <= 1'b0;
      overrun   <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      rx_clear  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rx_cnt_q  <= rx_cnt_d;
      tmo_q     <= tmo_d;
      frame_q   <= frame_d;
      target_q  <= target_d;
      mac_idx_q <= mac_idx_d;
      acc_q     <= acc_d;
      tx_word_q <= tx_word_d;
      tx_byte_q <= tx_byte_d;
      x_q       <= x_d;
      w_q       <= w_d;
      result    <= result_d;
      overrun   <= overrun_d;
      tx_start  <= tx_start_d;
      tx_data   <= tx_data_d;
      rx_clear  <= rx_clear_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_perceptron_uart_ctrl.sv
// Bench for perceptron_uart_ctrl: directed protocol scenarios plus randomized
// load/eval/train/read rounds against an arithmetic perceptron model.
module tb_perceptron_uart_ctrl;

  localparam int unsigned NI  = 2;
  localparam int unsigned DW  = 16;
  localparam int unsigned RS  = 0;
  localparam int unsigned TMO = 40;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst, rx_valid, rx_error, tx_busy;
  logic [7:0] rx_data;
  logic       rx_clear, tx_start, busy, result, overrun;
  logic [7:0] tx_data;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  bq_t txq;
  int mx [NI];
  int mw [NI];

  perceptron_uart_ctrl #(
    .N_INPUTS(NI), .DATA_W(DW), .RATE_SHIFT(RS), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
    .rx_clear(rx_clear), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .busy(busy), .result(result), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // UART transmitter stand-in: captures sent bytes, stays busy a random while
  initial tx_busy = 1'b0;
  always @(negedge clk) begin
    if (tx_start) begin
      txq.push_back(tx_data);
      busy_cnt = $urandom_range(1, 5);
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt > 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic
  function automatic int clamp(input longint v);
    longint hi = (longint'(1) <<< (DW - 1)) - 1;
    longint lo = -(longint'(1) <<< (DW - 1));
    if (v > hi) return int'(hi);
    if (v < lo) return int'(lo);
    return int'(v);
  endfunction

  function automatic logic model_result();
    longint s = 0;
    for (int i = 0; i < NI; i++) s += longint'(mx[i]) * longint'(mw[i]);
    return (s > 0);
  endfunction

  function automatic int rnd16();
    logic [15:0] v = 16'($urandom);
    case ($urandom_range(0, 5))
      0: v = 16'h7FFF;
      1: v = 16'h8000;
      default: ;
    endcase
    return int'($signed(v));
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || tx_busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic expect_reply(input string tag, input bq_t exp);
    int n = 0;
    while ((txq.size() < exp.size() || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check({tag, "_len"}, 32'(txq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i),
            (i < txq.size()) ? 32'(txq[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    end
    txq.delete();
  endtask

  task automatic cmd_load(input bit is_w);
    logic [15:0] v;
    bq_t none;
    wait_idle();
    send_byte(is_w ? 8'h02 : 8'h01);
    for (int i = 0; i < NI; i++) begin
      v = 16'(is_w ? mw[i] : mx[i]);
      send_byte(v[15:8]);
      send_byte(v[7:0]);
    end
    expect_reply(is_w ? "load_w" : "load_in", none);
  endtask

  task automatic cmd_eval(input string tag);
    bq_t e;
    logic r = model_result();
    e.push_back({7'b0, r});
    wait_idle();
    send_byte(8'h03);
    expect_reply(tag, e);
    check({tag, "_result"}, 32'(result), 32'(r));
  endtask

  task automatic cmd_train(input string tag, input logic t);
    bq_t e;
    logic [7:0] pb = 8'($urandom);
    logic r = model_result();
    pb[0] = t;
    e.push_back({7'b0, r});
    if (t != r) begin
      for (int i = 0; i < NI; i++)
        mw[i] = clamp(longint'(mw[i]) + (t ? 1 : -1) * longint'(mx[i] >>> RS));
    end
    wait_idle();
    send_byte(8'h04);
    send_byte(pb);
    expect_reply(tag, e);
  endtask

  task automatic cmd_read_w(input string tag);
    bq_t e;
    logic [15:0] v;
    for (int i = 0; i < NI; i++) begin
      v = 16'(mw[i]);
      e.push_back(v[15:8]);
      e.push_back(v[7:0]);
    end
    wait_idle();
    send_byte(8'h05);
    expect_reply(tag, e);
  endtask

  initial begin
    bq_t none;
    bq_t ee;
    int  lat;
    int  n;

    rst = 1'b1; rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_result", 32'(result), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_rx_clear", 32'(rx_clear), 0);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin mx[i] = 0; mw[i] = 0; end

    // Basic evaluation with latency measurement
    mx[0] = 3; mx[1] = -2; cmd_load(1'b0);
    mw[0] = 5; mw[1] = 4;  cmd_load(1'b1);
    wait_idle();
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h03;
    lat = 0;
    do begin
      @(negedge clk);
      rx_valid = 1'b0;
      lat++;
    end while (!tx_start && lat < 50);
    check("eval_latency", 32'(lat), 32'(NI + 2));
    ee.push_back({7'b0, model_result()});
    expect_reply("eval_basic", ee);
    check("eval_basic_result", 32'(result), 1);

    // Training with target 0 after a positive result, then readback
    cmd_train("train_t0", 1'b0);
    cmd_read_w("read_after_t0");

    // Zero sum counts as 0; training saturates w0
    mx[0] = 1; mx[1] = -1; cmd_load(1'b0);
    mw[0] = 32'h7FFF; mw[1] = 32'h7FFF; cmd_load(1'b1);
    cmd_train("train_sat", 1'b1);
    cmd_read_w("read_sat");

    // Payload timeout discards a partial weight frame
    wait_idle();
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (TMO - 8) @(negedge clk);
    check("tmo_still_busy", 32'(busy), 1);
    repeat (16) @(negedge clk);
    check("tmo_idle", 32'(busy), 0);
    expect_reply("tmo_noreply", none);
    cmd_read_w("read_after_tmo");

    // Unknown opcode plus a byte dropped during the reply
    wait_idle();
    check("overrun_before", 32'(overrun), 0);
    ee.delete();
    ee.push_back(8'hEE);
    send_byte(8'h7A);
    send_byte(8'h03);
    expect_reply("bad_opcode", ee);
    check("overrun_after", 32'(overrun), 1);

    // Framing error mid-frame: clear pulse, frame discarded
    wait_idle();
    send_byte(8'h01);
    send_byte(8'h80);
    send_byte(8'h00);
    @(negedge clk); rx_error = 1'b1;
    @(negedge clk); rx_error = 1'b0;
    check("err_rx_clear", 32'(rx_clear), 1);
    check("err_busy", 32'(busy), 0);
    @(negedge clk);
    check("err_rx_clear_end", 32'(rx_clear), 0);
    expect_reply("err_noreply", none);
    cmd_eval("eval_after_err");

    // Byte with simultaneous error is not taken as an opcode
    wait_idle();
    @(negedge clk); rx_valid = 1'b1; rx_error = 1'b1; rx_data = 8'h03;
    @(negedge clk); rx_valid = 1'b0; rx_error = 1'b0;
    check("valid_err_clear", 32'(rx_clear), 1);
    expect_reply("valid_err_noreply", none);

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NI; i++) begin mx[i] = rnd16(); mw[i] = rnd16(); end
      cmd_load(1'b0);
      cmd_load(1'b1);
      cmd_eval($sformatf("rnd%0d_eval", r));
      cmd_train($sformatf("rnd%0d_train", r), 1'($urandom));
      cmd_read_w($sformatf("rnd%0d_read", r));
    end

    // Reset in the middle of a weight readback aborts it
    wait_idle();
    send_byte(8'h05);
    n = 0;
    while (txq.size() < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    txq.delete();
    repeat (30) @(negedge clk);
    check("midrst_no_tx", 32'(txq.size()), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_overrun", 32'(overrun), 0);
    check("midrst_result", 32'(result), 0);
    for (int i = 0; i < NI; i++) begin mx[i] = 0; mw[i] = 0; end
    cmd_read_w("read_after_rst");
    cmd_eval("eval_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perceptron_uart_ctrl.md
PERCEPTRON_UART_CTRL -- requirements
Module: perceptron_uart_ctrl

Interface
REQ-001 SHALL have parameter N_INPUTS, default 4, number of perceptron inputs/weights (legal 1..16).
REQ-002 SHALL have parameter DATA_W, default 16, signed input/weight width (multiple of 8, 8..32).
REQ-003 SHALL have parameter RATE_SHIFT, default 0, training rate as arithmetic right shift of x_i.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 120000, max idle cycles between payload bytes.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge; one clock, reset is synchronous and active-high, on port rst  in  1.
REQ-006 SHALL have ports: rx_valid  in  1  one-cycle pulse, rx_data valid; rx_data  in  8  received byte; rx_error  in  1  UART framing error pulse.
REQ-007 SHALL have ports: rx_clear  out  1  one-cycle pulse clearing UART error; tx_start  out  1  one-cycle send request; tx_data  out  8  byte to send; tx_busy  in  1  UART transmitting.
REQ-008 SHALL have ports: busy  out  1  not in IDLE; result  out  1  last perceptron output; overrun  out  1  sticky dropped-byte flag.

Function
REQ-009 SHALL store N_INPUTS signed inputs x_i and weights w_i, each DATA_W bits, two's complement.
REQ-010 SHALL parse opcodes in IDLE: 0x01 LOAD_IN, 0x02 LOAD_W, 0x03 EVAL, 0x04 TRAIN, 0x05 READ_W; any other -> reply single byte 0xEE.
REQ-011 LOAD_IN/LOAD_W SHALL take N_INPUTS*DATA_W/8 payload bytes, index 0 first, MSB first per word; registers updated only after last byte; no reply.
REQ-012 TRAIN SHALL take one payload byte; bit0 = target t; other bits ignored.
REQ-013 States: IDLE, RX_PAYLOAD, MAC, UPDATE, TX_BYTE, TX_WAIT; UPDATE entered only from MAC on TRAIN.
REQ-014 MAC SHALL use one multiplier, one product per cycle, N_INPUTS cycles; accumulator width 2*DATA_W+clog2(N_INPUTS)+1, no overflow.
REQ-015 result SHALL be 1 iff signed sum > 0, registered at MAC end; sum == 0 -> 0.
REQ-016 UPDATE (one cycle): e = t - result; if e != 0, w_i += e * (x_i >>> RATE_SHIFT), saturating to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; e == 0 leaves weights unchanged.
REQ-017 EVAL and TRAIN SHALL reply one byte {7'b0, result} (result after MAC, before update).
REQ-018 READ_W SHALL reply all weights, index 0 first, MSB first.
REQ-019 tx_start SHALL pulse one cycle only when tx_busy is low; tx_data stable from tx_start until next tx_start; tx_busy ignored the cycle after tx_start, next byte waits for tx_busy low.
REQ-020 EVAL latency: tx_start exactly N_INPUTS+2 cycles after opcode rx_valid when tx_busy low.
REQ-021 rx_valid outside IDLE/RX_PAYLOAD: byte dropped, overrun set; overrun cleared only by reset.
REQ-022 RX_PAYLOAD: counter reloads on each byte; reaching TIMEOUT_CYC -> IDLE, frame discarded, registers unchanged, no reply.
REQ-023 rx_error in any state: rx_clear pulsed next cycle; in RX_PAYLOAD frame discarded -> IDLE; elsewhere ignored.
REQ-024 rx_valid and rx_error same cycle: byte discarded, error handling per REQ-023.

Reset
REQ-025 rst high at a clock edge SHALL force IDLE, all x_i and w_i to 0, result 0, overrun 0, tx_start 0, tx_data 0x00, rx_clear 0, busy 0.
REQ-026 rst mid-frame or mid-reply SHALL abort; no further tx_start until a new command after rst low.

Verification (N_INPUTS=2, DATA_W=16, RATE_SHIFT=0)
REQ-027 LOAD_IN 00 03 FF FE, LOAD_W 00 05 00 04, EVAL -> sum 7, reply 0x01, tx_start 4 cycles after opcode.
REQ-028 Then TRAIN 00 -> reply 0x01; READ_W -> 00 02 00 06.
REQ-029 x=(1,-1), w=(7FFF,7FFF), TRAIN 01 -> sum 0, reply 0x00; READ_W -> 7F FF 7F FE (saturation on w0).
REQ-030 LOAD_W opcode plus 2 bytes then TIMEOUT_CYC idle cycles -> IDLE, no reply, READ_W returns prior weights.
REQ-031 Opcode 0x7A -> reply 0xEE; byte sent during reply -> overrun 1, reply unaffected.
REQ-032 rx_error during LOAD_IN payload -> rx_clear pulse next cycle, inputs unchanged, next EVAL reply unchanged.
